pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives write-enables and bubble/flush controls of PC, IF/ID, ID/EX and the EX-side stage register.
- Resolves load-use hazards, taken jumps/branches decided in ID, multi-cycle EX operations, and an external halt request.
- Sits beside the datapath; it consumes decoded ID/EX fields and produces only control.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_hazard_detect.sv | 36 +++
 rtl/pipeline_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Brief    : Shared types and constants for the pipeline stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

   localparam int REG_AW_DEFAULT = 5;
   localparam int ZERO_REG       = 0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MULTI = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ============================================================================
// Module   : hazard_detect
// Brief    : Load-use compare between the EX load target and the ID sources.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic [REG_AW-1:0] i_id_rs,
   input  logic [REG_AW-1:0] i_id_rt,
   input  logic              i_id_uses_rt,
   input  logic [REG_AW-1:0] i_ex_rd,
   input  logic              i_ex_wb,
   input  logic              i_ex_is_load,
   output logic              o_hazard
);

   localparam logic [REG_AW-1:0] c_ZERO = REG_AW'(ZERO_REG);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (i_ex_rd == i_id_rs);
   assign w_rt_match = i_id_uses_rt && (i_ex_rd == i_id_rt);

   // Register 0 is hard-wired, so a load targeting it can never feed a consumer.
   assign o_hazard = i_ex_is_load && i_ex_wb && (i_ex_rd != c_ZERO)
                     && (w_rs_match || w_rt_match);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline; optional
//            performance counters enabled by PIPELINE_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int REG_AW  = REG_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_id,
   input  logic              branch_taken_id,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_wb,
   input  logic              ex_is_load,
   input  logic              ex_multi,
   input  logic              halt_req,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_en,
   output logic              idex_bubble,
   output logic              exmem_bubble,
   output logic              busy,
`ifdef PIPELINE_CTRL_PERF_EN
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_count,
`endif
   output logic [1:0]        state
);

   localparam logic       c_MULTI_EN = (MUL_LAT >= 2);
   localparam logic [7:0] c_CNT_LOAD = 8'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

   state_t     r_state;
   logic [7:0] r_cnt;
   state_t     w_next_state;
   logic [7:0] w_next_cnt;
   logic       w_hazard;
   logic       w_redirect;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .i_id_rs      (id_rs),
      .i_id_rt      (id_rt),
      .i_id_uses_rt (id_uses_rt),
      .i_ex_rd      (ex_rd),
      .i_ex_wb      (ex_wb),
      .i_ex_is_load (ex_is_load),
      .o_hazard     (w_hazard)
   );

   assign w_redirect = jump_id || branch_taken_id;

   always_comb begin
      // Baseline is the RUN-state decision for load-use and redirect; a stall
      // suppresses the flush so the redirect is re-evaluated next cycle.
      pc_en        = !w_hazard;
      ifid_en      = !w_hazard;
      ifid_flush   = !w_hazard && w_redirect;
      idex_en      = 1'b1;
      idex_bubble  = w_hazard;
      exmem_bubble = 1'b0;
      w_next_state = r_state;
      w_next_cnt   = r_cnt;

      if (rst) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         ifid_flush   = 1'b1;
         idex_en      = 1'b0;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (halt_req) begin
                  w_next_state = ST_HALT;
               end else if (c_MULTI_EN && ex_multi) begin
                  pc_en        = 1'b0;
                  ifid_en      = 1'b0;
                  ifid_flush   = 1'b0;
                  idex_en      = 1'b0;
                  idex_bubble  = 1'b0;
                  exmem_bubble = 1'b1;
                  w_next_cnt   = c_CNT_LOAD;
                  w_next_state = ST_MULTI;
               end
            end
            ST_MULTI: begin
               if (r_cnt != 8'd0) begin
                  pc_en        = 1'b0;
                  ifid_en      = 1'b0;
                  ifid_flush   = 1'b0;
                  idex_en      = 1'b0;
                  idex_bubble  = 1'b0;
                  exmem_bubble = 1'b1;
                  w_next_cnt   = r_cnt - 8'd1;
               end else begin
                  w_next_state = halt_req ? ST_HALT : ST_RUN;
               end
            end
            ST_HALT: begin
               pc_en        = 1'b0;
               ifid_en      = 1'b0;
               ifid_flush   = 1'b0;
               idex_en      = 1'b0;
               idex_bubble  = 1'b0;
               exmem_bubble = 1'b0;
               if (!halt_req) begin
                  w_next_state = ST_RUN;
               end
            end
            default: begin
               w_next_state = ST_RUN;
               w_next_cnt   = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   assign state = r_state;
   assign busy  = !rst && ((r_state == ST_MULTI) || (r_state == ST_HALT));

`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= 32'd0;
         r_flush_count  <= 32'd0;
      end else begin
         if (!pc_en && (r_state != ST_HALT) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (ifid_flush && (r_flush_count != 32'hFFFF_FFFF)) begin
            r_flush_count <= r_flush_count + 32'd1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed and randomized checks of pipeline_ctrl against a
//            behavioural model of the stall/flush rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

   localparam int MUL_LAT = 4;
   localparam int REG_AW  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              jump_id, branch_taken_id, id_uses_rt;
   logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
   logic              ex_wb, ex_is_load, ex_multi, halt_req;
   logic              pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, busy;
   logic [1:0]        state;
`ifdef PIPELINE_CTRL_PERF_EN
   logic [31:0]       stall_cycles, flush_count;
   int                m_stall, m_flush;
`endif

   int checks = 0;
   int errors = 0;

   // Model: mode 0=running, 1=in multi-cycle op, 2=halted; left = freeze cycles remaining
   int m_mode = 0;
   int m_left = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MUL_LAT(MUL_LAT), .REG_AW(REG_AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .jump_id         (jump_id),
      .branch_taken_id (branch_taken_id),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .ex_rd           (ex_rd),
      .ex_wb           (ex_wb),
      .ex_is_load      (ex_is_load),
      .ex_multi        (ex_multi),
      .halt_req        (halt_req),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_en         (idex_en),
      .idex_bubble     (idex_bubble),
      .exmem_bubble    (exmem_bubble),
      .busy            (busy),
`ifdef PIPELINE_CTRL_PERF_EN
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count),
`endif
      .state           (state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      jump_id = 0; branch_taken_id = 0; id_uses_rt = 0;
      id_rs = 0; id_rt = 0; ex_rd = 0;
      ex_wb = 0; ex_is_load = 0; ex_multi = 0; halt_req = 0;
   endtask

   // Output vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, busy}
   task automatic cycle(input string tag);
      logic [6:0] exp;
      logic       hz, redir;
      int         nmode, nleft;
      #2;
      hz = ex_is_load && ex_wb && (ex_rd != 0)
           && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      redir = jump_id || branch_taken_id;
      nmode = m_mode;
      nleft = m_left;
      if (hz) exp = 7'b0001100;
      else    exp = {2'b11, redir, 4'b1000};
      if (rst) begin
         exp = 7'b0010110;
         nmode = 0; nleft = 0;
      end else if (m_mode == 0) begin
         if (halt_req) nmode = 2;
         else if (ex_multi && MUL_LAT >= 2) begin
            exp = 7'b0000010;
            nmode = 1;
            nleft = MUL_LAT - 2;
         end
      end else if (m_mode == 1) begin
         if (m_left > 0) begin
            exp = 7'b0000011;
            nleft = m_left - 1;
         end else begin
            exp[0] = 1'b1;
            nmode = halt_req ? 2 : 0;
         end
      end else begin
         exp = 7'b0000001;
         if (!halt_req) nmode = 0;
      end
      chk({tag, ".outs"}, 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, busy}),
          32'(exp));
      chk({tag, ".state"}, 32'(state), 32'(m_mode));
`ifdef PIPELINE_CTRL_PERF_EN
      chk({tag, ".stall_cycles"}, stall_cycles, 32'(m_stall));
      chk({tag, ".flush_count"}, flush_count, 32'(m_flush));
      if (rst) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (!exp[6] && m_mode != 2) m_stall++;
         if (exp[4]) m_flush++;
      end
`endif
      @(posedge clk);
      m_mode = nmode;
      m_left = nleft;
      @(negedge clk);
   endtask

   initial begin
      int halt_hold;
      idle_inputs();
      rst = 1;
`ifdef PIPELINE_CTRL_PERF_EN
      m_stall = 0; m_flush = 0;
`endif
      @(negedge clk);

      // Reset held two cycles, then release into RUN
      cycle("reset0");
      cycle("reset1");
      rst = 0;
      cycle("release");

      // Load-use through rs, then the same with ex_rd=0
      ex_is_load = 1; ex_wb = 1; ex_rd = 5; id_rs = 5;
      cycle("lu_rs");
      ex_rd = 0; id_rs = 0;
      cycle("lu_zero");

      // Load-use through rt with a held branch: stall first, flush once clear
      id_rs = 3; ex_rd = 5; id_rt = 5; id_uses_rt = 1; branch_taken_id = 1;
      cycle("lu_br_stall");
      ex_is_load = 0;
      cycle("lu_br_flush");
      idle_inputs();
      cycle("idle");

      // Single multi-cycle op
      ex_multi = 1;
      cycle("mul_start");
      ex_multi = 0;
      for (int i = 0; i < MUL_LAT; i++) cycle("mul_run");

      // Halt raised mid-op, held past completion, then dropped
      ex_multi = 1;
      cycle("mh_start");
      ex_multi = 0; halt_req = 1;
      for (int i = 0; i < 5; i++) cycle("mh_hold");
      halt_req = 0;
      cycle("mh_drop");
      cycle("mh_after");

      // Back-to-back multi-cycle ops
      ex_multi = 1;
      for (int i = 0; i < 2 * MUL_LAT; i++) cycle("mul_b2b");
      ex_multi = 0;
      cycle("mul_b2b_end");

      // Randomized traffic with small register range to provoke hazards
      halt_hold = 0;
      for (int i = 0; i < 400; i++) begin
         id_rs           = REG_AW'($urandom_range(0, 3));
         id_rt           = REG_AW'($urandom_range(0, 3));
         ex_rd           = REG_AW'($urandom_range(0, 3));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_wb           = 1'($urandom_range(0, 3) != 0);
         ex_is_load      = 1'($urandom_range(0, 1));
         jump_id         = 1'($urandom_range(0, 5) == 0);
         branch_taken_id = 1'($urandom_range(0, 4) == 0);
         ex_multi        = 1'($urandom_range(0, 7) == 0);
         if (halt_hold > 0) halt_hold--;
         else if ($urandom_range(0, 19) == 0) halt_hold = $urandom_range(1, 4);
         halt_req = (halt_hold > 0);
         if (halt_req) ex_multi = 0;
         rst = ($urandom_range(0, 59) == 0);
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
